// File: rtl/zion_riscv_isa_lib_bj_redirect.sv
// Branch/jump resolve: registered redirect held until fetch accepts it, 1-cycle flush, link-PC writeback.
// 1-cycle latency; oReady drops while a redirect waits. ZION_RISCV_BJ_REDIRECT_MISALIGN_EXC_EN enables misaligned-target traps.
module zion_riscv_isa_lib_bj_redirect #(
  parameter int RV64 = 0,
  parameter int CNT_WIDTH = 32,
  localparam int CPU_WIDTH = 32 * (RV64 + 1)
) (
  input  logic                 iClk,
  input  logic                 iRstN,
  input  logic                 iValid,
  output logic                 oReady,
  input  logic                 iBranch,
  input  logic                 iJump,
  input  logic                 iBjEn,
  input  logic                 iPredTaken,
  input  logic [CPU_WIDTH-1:0] iPredTgt,
  input  logic [CPU_WIDTH-1:0] iTgtAddr,
  input  logic [CPU_WIDTH-1:0] iLinkPc,
  input  logic [CPU_WIDTH-1:0] iSeqPc,
  input  logic [CPU_WIDTH-1:0] iPc,
  input  logic                 iRdEn,
  output logic                 oRedirValid,
  input  logic                 iRedirReady,
  output logic [CPU_WIDTH-1:0] oRedirPc,
  output logic                 oFlush,
  output logic                 oWbValid,
  output logic [CPU_WIDTH-1:0] oWbData,
  output logic [CNT_WIDTH-1:0] oMispredCnt,
  output logic                 oExcValid,
  output logic [CPU_WIDTH-1:0] oExcPc,
  output logic [CPU_WIDTH-1:0] oExcTval
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]           state;
  logic                 accept;
  logic                 isBj;
  logic                 mispred;
  logic                 excHit;
  logic                 redirHit;
  logic                 wbHit;
  logic                 unusedBits;
  logic [CPU_WIDTH-1:0] tgt;
  logic [CPU_WIDTH-1:0] redirPcNxt;

  assign oReady     = (state == IDLE);
  assign accept     = iValid & oReady;
  assign isBj       = iBranch | iJump;
  assign tgt        = {iTgtAddr[CPU_WIDTH-1:1], 1'b0};
  assign mispred    = isBj & ((iBjEn != iPredTaken) | (iBjEn & iPredTaken & (tgt != iPredTgt)));
  assign redirPcNxt = iBjEn ? tgt : iSeqPc;

  // A trapping instruction suppresses its own redirect and writeback.
  assign redirHit = accept & mispred & ~excHit;
  assign wbHit    = accept & iJump & iRdEn & ~excHit;

`ifdef ZION_RISCV_BJ_REDIRECT_MISALIGN_EXC_EN
  assign excHit     = accept & isBj & iBjEn & tgt[1];
  assign unusedBits = iTgtAddr[0];

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      oExcValid <= 1'b0;
      oExcPc    <= '0;
      oExcTval  <= '0;
    end else begin
      oExcValid <= excHit;
      if (excHit) begin
        oExcPc   <= iPc;
        oExcTval <= tgt;
      end
    end
  end
`else
  assign excHit     = 1'b0;
  assign unusedBits = ^{iTgtAddr[0], iPc};
  assign oExcValid  = 1'b0;
  assign oExcPc     = '0;
  assign oExcTval   = '0;
`endif

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      state       <= IDLE;
      oRedirValid <= 1'b0;
      oRedirPc    <= '0;
      oFlush      <= 1'b0;
      oWbValid    <= 1'b0;
      oWbData     <= '0;
      oMispredCnt <= '0;
    end else begin
      oFlush   <= redirHit | excHit;
      oWbValid <= wbHit;
      if (wbHit) begin
        oWbData <= iLinkPc;
      end
      case (state)
        IDLE: begin
          if (redirHit) begin
            state       <= WAIT;
            oRedirValid <= 1'b1;
            oRedirPc    <= redirPcNxt;
            if (!(&oMispredCnt)) begin
              oMispredCnt <= oMispredCnt + CNT_WIDTH'(1);
            end
          end
        end
        WAIT: begin
          if (iRedirReady) begin
            state       <= IDLE;
            oRedirValid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zion_riscv_isa_lib_bj_redirect.sv
// Bench for zion_riscv_isa_lib_bj_redirect (RV32, 4-bit mispredict counter): directed cases plus randomized traffic.
module tb_zion_riscv_isa_lib_bj_redirect;
  localparam int W = 32;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          iClk = 1'b0;
  logic          iRstN;
  logic          iValid;
  logic          oReady;
  logic          iBranch, iJump, iBjEn, iPredTaken, iRdEn;
  logic [W-1:0]  iPredTgt, iTgtAddr, iLinkPc, iSeqPc, iPc;
  logic          oRedirValid;
  logic          iRedirReady;
  logic [W-1:0]  oRedirPc;
  logic          oFlush, oWbValid, oExcValid;
  logic [W-1:0]  oWbData, oExcPc, oExcTval;
  logic [CW-1:0] oMispredCnt;

  int checks = 0;
  int errors = 0;
  int expCnt = 0;

  always #5 iClk = ~iClk;

  zion_riscv_isa_lib_bj_redirect #(.RV64(0), .CNT_WIDTH(CW)) dut (
    .iClk(iClk), .iRstN(iRstN), .iValid(iValid), .oReady(oReady),
    .iBranch(iBranch), .iJump(iJump), .iBjEn(iBjEn), .iPredTaken(iPredTaken),
    .iPredTgt(iPredTgt), .iTgtAddr(iTgtAddr), .iLinkPc(iLinkPc), .iSeqPc(iSeqPc),
    .iPc(iPc), .iRdEn(iRdEn), .oRedirValid(oRedirValid), .iRedirReady(iRedirReady),
    .oRedirPc(oRedirPc), .oFlush(oFlush), .oWbValid(oWbValid), .oWbData(oWbData),
    .oMispredCnt(oMispredCnt), .oExcValid(oExcValid), .oExcPc(oExcPc), .oExcTval(oExcTval)
  );

  typedef struct {
    bit br, jmp, bjEn, predTaken, rdEn;
    logic [W-1:0] predTgt, tgtAddr, linkPc, seqPc, pc;
  } instr_t;

  typedef struct {
    bit redir, flush, wb, exc;
    logic [W-1:0] redirPc, wbData, excPc, excTval;
  } exp_t;

  // Reference: what one accepted instruction should cause, straight from the resolve rules.
  function automatic exp_t model(input instr_t x);
    exp_t e;
    logic [W-1:0] t;
    bit isBj, miss, misalign;
    e.redir = 0; e.flush = 0; e.wb = 0; e.exc = 0;
    e.redirPc = 0; e.wbData = 0; e.excPc = 0; e.excTval = 0;
    isBj = x.br || x.jmp;
    t = x.tgtAddr - (x.tgtAddr % 2);
    if (x.bjEn) miss = isBj && (!x.predTaken || t != x.predTgt);
    else        miss = isBj && x.predTaken;
    misalign = 0;
`ifdef ZION_RISCV_BJ_REDIRECT_MISALIGN_EXC_EN
    misalign = isBj && x.bjEn && ((t / 2) % 2 == 1);
`endif
    if (misalign) begin
      e.flush = 1; e.exc = 1; e.excPc = x.pc; e.excTval = t;
    end else begin
      if (miss) begin
        e.redir = 1; e.flush = 1;
        e.redirPc = x.bjEn ? t : x.seqPc;
      end
      if (x.jmp && x.rdEn) begin
        e.wb = 1; e.wbData = x.linkPc;
      end
    end
    return e;
  endfunction

  function automatic int satInc(input int c);
    return (c < CNT_MAX) ? c + 1 : c;
  endfunction

  function automatic instr_t mk(input bit br, input bit jmp, input bit bjEn, input bit pt, input bit rd,
                                input logic [W-1:0] predTgt, input logic [W-1:0] tgt,
                                input logic [W-1:0] link, input logic [W-1:0] seq, input logic [W-1:0] pc);
    instr_t x;
    x.br = br; x.jmp = jmp; x.bjEn = bjEn; x.predTaken = pt; x.rdEn = rd;
    x.predTgt = predTgt; x.tgtAddr = tgt; x.linkPc = link; x.seqPc = seq; x.pc = pc;
    return x;
  endfunction

  task automatic present(input instr_t x);
    iValid = 1'b1; iBranch = x.br; iJump = x.jmp; iBjEn = x.bjEn; iPredTaken = x.predTaken;
    iRdEn = x.rdEn; iPredTgt = x.predTgt; iTgtAddr = x.tgtAddr; iLinkPc = x.linkPc;
    iSeqPc = x.seqPc; iPc = x.pc;
  endtask

  task automatic tick;
    @(posedge iClk);
    #1;
  endtask

  task automatic test_reset;
    iRstN = 1'b0;
    repeat (2) tick();
    iRstN = 1'b1;
    expCnt = 0;
    checks++;
    if ({oRedirValid, oFlush, oWbValid, oExcValid} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes got %b want 0000", {oRedirValid, oFlush, oWbValid, oExcValid});
    end
    checks++;
    if ((oRedirPc | oWbData | oExcPc | oExcTval) !== '0) begin
      errors++; $display("FAIL reset_data got %h/%h/%h/%h want 0", oRedirPc, oWbData, oExcPc, oExcTval);
    end
    checks++;
    if (oMispredCnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", oMispredCnt); end
    checks++;
    if (oReady !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", oReady); end
  endtask

  task automatic test_beq_mispredict;
    present(mk(1, 0, 1, 0, 0, 32'h0, 32'h1000, 32'h204, 32'h204, 32'h200));
    tick();
    iValid = 1'b0;
    expCnt = satInc(expCnt);
    checks++;
    if (oRedirValid !== 1'b1 || oRedirPc !== 32'h1000) begin
      errors++; $display("FAIL beq_redirect got v=%b pc=%h want v=1 pc=00001000", oRedirValid, oRedirPc);
    end
    checks++;
    if (oFlush !== 1'b1) begin errors++; $display("FAIL beq_flush got %b want 1", oFlush); end
    checks++;
    if (oMispredCnt !== 4'd1) begin errors++; $display("FAIL beq_cnt got %0d want 1", oMispredCnt); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (oRedirValid !== 1'b1 || oRedirPc !== 32'h1000 || oReady !== 1'b0 || oFlush !== 1'b0) begin
        errors++;
        $display("FAIL beq_hold%0d got v=%b pc=%h rdy=%b fl=%b want v=1 pc=00001000 rdy=0 fl=0",
                 i, oRedirValid, oRedirPc, oReady, oFlush);
      end
    end
    iRedirReady = 1'b1;
    tick();
    iRedirReady = 1'b0;
    checks++;
    if (oRedirValid !== 1'b0 || oReady !== 1'b1) begin
      errors++; $display("FAIL beq_release got v=%b rdy=%b want v=0 rdy=1", oRedirValid, oReady);
    end
  endtask

  task automatic test_jal_writeback;
    present(mk(0, 1, 1, 1, 1, 32'h2000, 32'h2000, 32'h0FFC, 32'h0FFC, 32'h0FF8));
    tick();
    iValid = 1'b0;
    checks++;
    if (oWbValid !== 1'b1 || oWbData !== 32'h0FFC) begin
      errors++; $display("FAIL jal_wb got v=%b d=%h want v=1 d=00000ffc", oWbValid, oWbData);
    end
    checks++;
    if (oRedirValid !== 1'b0 || oFlush !== 1'b0 || oReady !== 1'b1) begin
      errors++; $display("FAIL jal_noredir got v=%b fl=%b rdy=%b want 0 0 1", oRedirValid, oFlush, oReady);
    end
    tick();
    checks++;
    if (oWbValid !== 1'b0) begin errors++; $display("FAIL jal_wb_pulse got %b want 0", oWbValid); end
  endtask

  // Fetch is already ready in the first redirect cycle, so the redirect lasts one cycle.
  task automatic test_jalr_target;
    present(mk(0, 1, 1, 1, 0, 32'h3000, 32'h3005, 32'h10, 32'h10, 32'hC));
    tick();
    iValid = 1'b0;
    expCnt = satInc(expCnt);
    checks++;
    if (oRedirValid !== 1'b1 || oRedirPc !== 32'h3004 || oFlush !== 1'b1) begin
      errors++; $display("FAIL jalr_redirect got v=%b pc=%h fl=%b want 1 00003004 1", oRedirValid, oRedirPc, oFlush);
    end
    iRedirReady = 1'b1;
    tick();
    iRedirReady = 1'b0;
    checks++;
    if (oRedirValid !== 1'b0 || oReady !== 1'b1 || oFlush !== 1'b0) begin
      errors++; $display("FAIL jalr_oneshot got v=%b rdy=%b fl=%b want 0 1 0", oRedirValid, oReady, oFlush);
    end
    checks++;
    if (oMispredCnt !== 4'(expCnt)) begin
      errors++; $display("FAIL jalr_cnt got %0d want %0d", oMispredCnt, expCnt);
    end
  endtask

  task automatic test_not_taken_saturate;
    for (int i = 0; i < 16; i++) begin
      present(mk(1, 0, 0, 1, 0, $urandom, $urandom, $urandom, 32'h404, 32'h400));
      tick();
      iValid = 1'b0;
      expCnt = satInc(expCnt);
      checks++;
      if (oRedirValid !== 1'b1 || oRedirPc !== 32'h404) begin
        errors++; $display("FAIL nt_redirect%0d got v=%b pc=%h want 1 00000404", i, oRedirValid, oRedirPc);
      end
      checks++;
      if (oMispredCnt !== 4'(expCnt)) begin
        errors++; $display("FAIL nt_cnt%0d got %0d want %0d", i, oMispredCnt, expCnt);
      end
      iRedirReady = 1'b1;
      tick();
      iRedirReady = 1'b0;
    end
    checks++;
    if (oMispredCnt !== 4'hF) begin errors++; $display("FAIL cnt_saturated got %h want f", oMispredCnt); end
  endtask

  task automatic test_misalign;
    present(mk(1, 0, 1, 0, 0, 32'h0, 32'h1002, 32'h804, 32'h804, 32'h800));
    tick();
    iValid = 1'b0;
`ifdef ZION_RISCV_BJ_REDIRECT_MISALIGN_EXC_EN
    checks++;
    if (oExcValid !== 1'b1 || oExcTval !== 32'h1002 || oExcPc !== 32'h800) begin
      errors++; $display("FAIL misalign_exc got v=%b tval=%h pc=%h want 1 00001002 00000800", oExcValid, oExcTval, oExcPc);
    end
    checks++;
    if (oFlush !== 1'b1 || oRedirValid !== 1'b0 || oReady !== 1'b1 || oMispredCnt !== 4'(expCnt)) begin
      errors++; $display("FAIL misalign_side got fl=%b v=%b rdy=%b cnt=%0d want 1 0 1 %0d",
                         oFlush, oRedirValid, oReady, oMispredCnt, expCnt);
    end
    tick();
    checks++;
    if (oExcValid !== 1'b0) begin errors++; $display("FAIL misalign_pulse got %b want 0", oExcValid); end
`else
    expCnt = satInc(expCnt);
    checks++;
    if (oRedirValid !== 1'b1 || oRedirPc !== 32'h1002 || oExcValid !== 1'b0) begin
      errors++; $display("FAIL misalign_redirect got v=%b pc=%h exc=%b want 1 00001002 0", oRedirValid, oRedirPc, oExcValid);
    end
    iRedirReady = 1'b1;
    tick();
    iRedirReady = 1'b0;
`endif
  endtask

  task automatic test_reset_in_wait;
    present(mk(1, 0, 1, 0, 0, 32'h0, 32'h1000, 32'h0, 32'h0, 32'h0));
    tick();
    iValid = 1'b0;
    checks++;
    if (oRedirValid !== 1'b1) begin errors++; $display("FAIL rstwait_pre got %b want 1", oRedirValid); end
    iRstN = 1'b0;
    tick();
    iRstN = 1'b1;
    expCnt = 0;
    checks++;
    if (oRedirValid !== 1'b0 || oFlush !== 1'b0 || oReady !== 1'b1 || oMispredCnt !== 4'd0) begin
      errors++; $display("FAIL rstwait_drop got v=%b fl=%b rdy=%b cnt=%0d want 0 0 1 0",
                         oRedirValid, oFlush, oReady, oMispredCnt);
    end
  endtask

  // Second mispredict is held by execute during WAIT and must only be taken after release.
  task automatic test_back_to_back;
    present(mk(1, 0, 1, 0, 0, 32'h0, 32'h5000, 32'h0, 32'h0, 32'h0));
    tick();
    expCnt = satInc(expCnt);
    present(mk(0, 1, 1, 0, 1, 32'h0, 32'h6000, 32'h77, 32'h0, 32'h0));
    repeat (2) tick();
    checks++;
    if (oRedirPc !== 32'h5000 || oWbValid !== 1'b0 || oMispredCnt !== 4'(expCnt)) begin
      errors++; $display("FAIL b2b_hold got pc=%h wb=%b cnt=%0d want 00005000 0 %0d", oRedirPc, oWbValid, oMispredCnt, expCnt);
    end
    iRedirReady = 1'b1;
    tick();
    iRedirReady = 1'b0;
    checks++;
    if (oRedirValid !== 1'b0 || oReady !== 1'b1) begin
      errors++; $display("FAIL b2b_gap got v=%b rdy=%b want 0 1", oRedirValid, oReady);
    end
    tick();
    iValid = 1'b0;
    expCnt = satInc(expCnt);
    checks++;
    if (oRedirValid !== 1'b1 || oRedirPc !== 32'h6000 || oWbValid !== 1'b1 || oWbData !== 32'h77) begin
      errors++; $display("FAIL b2b_second got v=%b pc=%h wb=%b d=%h want 1 00006000 1 00000077",
                         oRedirValid, oRedirPc, oWbValid, oWbData);
    end
    iRedirReady = 1'b1;
    tick();
    iRedirReady = 1'b0;
  endtask

  task automatic test_random;
    instr_t x;
    exp_t e;
    int kind, hold;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        tick();
        checks++;
        if (oFlush !== 1'b0 || oWbValid !== 1'b0 || oExcValid !== 1'b0 || oReady !== 1'b1) begin
          errors++; $display("FAIL rnd_idle%0d got fl=%b wb=%b exc=%b rdy=%b want 0 0 0 1", n, oFlush, oWbValid, oExcValid, oReady);
        end
      end
      kind = $urandom_range(0, 3);
      x.br = (kind == 1 || kind == 3);
      x.jmp = (kind == 2);
      x.bjEn = x.jmp ? 1'b1 : 1'($urandom_range(0, 1));
      x.predTaken = 1'($urandom_range(0, 1));
      x.rdEn = 1'($urandom_range(0, 1));
      x.tgtAddr = $urandom;
      x.predTgt = ($urandom_range(0, 1) == 1) ? (x.tgtAddr - (x.tgtAddr % 2)) : $urandom;
      x.linkPc = $urandom; x.seqPc = $urandom; x.pc = $urandom;
      e = model(x);
      present(x);
      tick();
      iValid = 1'b0;
      if (e.redir) expCnt = satInc(expCnt);
      checks++;
      if (oRedirValid !== e.redir || oFlush !== e.flush || oWbValid !== e.wb || oExcValid !== e.exc) begin
        errors++; $display("FAIL rnd_strobes%0d got v=%b fl=%b wb=%b exc=%b want %b %b %b %b",
                           n, oRedirValid, oFlush, oWbValid, oExcValid, e.redir, e.flush, e.wb, e.exc);
      end
      checks++;
      if ((e.redir && oRedirPc !== e.redirPc) || (e.wb && oWbData !== e.wbData) ||
          (e.exc && (oExcPc !== e.excPc || oExcTval !== e.excTval))) begin
        errors++; $display("FAIL rnd_data%0d got pc=%h wb=%h epc=%h tval=%h want %h %h %h %h",
                           n, oRedirPc, oWbData, oExcPc, oExcTval, e.redirPc, e.wbData, e.excPc, e.excTval);
      end
      checks++;
      if (oMispredCnt !== 4'(expCnt)) begin
        errors++; $display("FAIL rnd_cnt%0d got %0d want %0d", n, oMispredCnt, expCnt);
      end
      if (e.redir) begin
        hold = $urandom_range(0, 3);
        for (int h = 0; h < hold; h++) begin
          tick();
          checks++;
          if (oRedirValid !== 1'b1 || oRedirPc !== e.redirPc || oReady !== 1'b0 || oFlush !== 1'b0) begin
            errors++; $display("FAIL rnd_hold%0d got v=%b pc=%h rdy=%b fl=%b want 1 %h 0 0",
                               n, oRedirValid, oRedirPc, oReady, oFlush, e.redirPc);
          end
        end
        iRedirReady = 1'b1;
        tick();
        iRedirReady = 1'b0;
        checks++;
        if (oRedirValid !== 1'b0 || oReady !== 1'b1) begin
          errors++; $display("FAIL rnd_release%0d got v=%b rdy=%b want 0 1", n, oRedirValid, oReady);
        end
      end
    end
  endtask

  initial begin
    iRstN = 1'b0; iValid = 1'b0; iBranch = 1'b0; iJump = 1'b0; iBjEn = 1'b0; iPredTaken = 1'b0;
    iRdEn = 1'b0; iPredTgt = '0; iTgtAddr = '0; iLinkPc = '0; iSeqPc = '0; iPc = '0; iRedirReady = 1'b0;
    test_reset();
    test_beq_mispredict();
    test_jal_writeback();
    test_jalr_target();
    test_not_taken_saturate();
    test_misalign();
    test_reset_in_wait();
    test_back_to_back();
    test_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/zion_riscv_isa_lib_bj_redirect.md
# zion_riscv_isa_lib_bj_redirect

Resolves each executed branch/jump against the fetch-stage prediction and issues a registered PC redirect to fetch. It sits directly downstream of the branch/jump execute logic and consumes its taken flag, target address and link PC. It produces a held redirect request (valid/ready), a one-cycle flush pulse for younger instructions, the link-PC writeback and a saturating mispredict counter.

## Interface
- RV64, 0, 1 selects RV64 and 0 selects RV32; CPU_WIDTH = 32*(RV64+1)
- CNT_WIDTH, 32, width of the mispredict counter
- iClk  in  1  clock
- iRstN  in  1  synchronous active-low reset
- iValid  in  1  resolved instruction presented by execute
- oReady  out  1  block can accept the instruction (combinational: state==IDLE)
- iBranch, iJump  in  1 each  instruction class
- iBjEn  in  1  taken (branch condition true, or any jump)
- iPredTaken  in  1  fetch predicted taken
- iPredTgt  in  CPU_WIDTH  fetch predicted target
- iTgtAddr  in  CPU_WIDTH  computed target
- iLinkPc  in  CPU_WIDTH  link PC (pc+2/4)
- iSeqPc  in  CPU_WIDTH  sequential fall-through PC
- iPc  in  CPU_WIDTH  instruction PC
- iRdEn  in  1  jump writes rd
- oRedirValid  out  1  redirect request
- iRedirReady  in  1  fetch accepts the redirect
- oRedirPc  out  CPU_WIDTH  redirect PC
- oFlush  out  1  one-cycle kill of younger instructions
- oWbValid  out  1  link-PC writeback strobe
- oWbData  out  CPU_WIDTH  link PC
- oMispredCnt  out  CNT_WIDTH  count of mispredicts
- oExcValid  out  1  misaligned-target exception (see Configuration)
- oExcPc, oExcTval  out  CPU_WIDTH  faulting PC and target
- The design uses one clock and a synchronous, active-low reset, iRstN.

## Operation
- An instruction is accepted when iValid & oReady. It is a BJ when iBranch|iJump. Non-BJ accepted beats are ignored.
- The effective target is tgt = {iTgtAddr[CPU_WIDTH-1:1],1'b0}, so bit 0 is always cleared.
- mispred = BJ & ((iBjEn != iPredTaken) | (iBjEn & iPredTaken & (tgt != iPredTgt))).
- Redirect PC = iBjEn ? tgt : iSeqPc.
- FSM states: IDLE and WAIT.
  - IDLE with an accepted mispredict: register oRedirPc, set oRedirValid=1, pulse oFlush, increment oMispredCnt, and go to WAIT.
  - WAIT: hold oRedirValid and oRedirPc stable. On iRedirReady, clear oRedirValid and return to IDLE.
  - oReady=0 throughout WAIT.
- Writeback: an accepted iJump & iRdEn gives oWbValid=1 for one cycle with oWbData=iLinkPc, registered. This applies whether or not the jump mispredicted.
- oMispredCnt saturates at all-ones and never wraps.
- Branches and jumps that are predicted correctly produce no redirect and no flush.

## Timing
- All outputs are registered except oReady. Latency from the accept edge to oRedirValid, oFlush and oWbValid is 1 cycle.
- oFlush is high only in the first cycle of oRedirValid.
- A redirect accepted in cycle N (oRedirValid & iRedirReady) gives oReady=1 in N+1. Back-to-back mispredicts are therefore separated by at least 1 idle-accept cycle.
- If iRedirReady is already high in the first oRedirValid cycle, the handshake completes in that cycle and the redirect lasts 1 cycle.
- Reset values: oRedirValid=0, oRedirPc=0, oFlush=0, oWbValid=0, oWbData=0, oMispredCnt=0, oExcValid=0, oExcPc=0, oExcTval=0, state=IDLE.
- A reset asserted during WAIT drops the redirect on the next edge with no flush.
- iValid while oReady=0 is not consumed. Execute must hold its inputs.

## Configuration
- ZION_RISCV_BJ_REDIRECT_MISALIGN_EXC_EN is defined:
  - A taken BJ with tgt[1]=1 raises an exception instead of redirecting.
  - oExcValid pulses for 1 cycle with oExcPc=iPc and oExcTval=tgt.
  - oFlush pulses; there is no redirect, no writeback and no counter increment.
  - The FSM stays in IDLE.
- Undefined:
  - oExcValid, oExcPc and oExcTval are tied to 0.
  - Misaligned targets redirect normally (the C extension is assumed present).

## Test plan
- Reset, then check: all outputs are 0 and oReady=1 on the first post-reset cycle.
- BEQ with iBjEn=1, iPredTaken=0, iTgtAddr=0x1000 -> next cycle oRedirValid=1, oRedirPc=0x1000, oFlush=1, oMispredCnt=1.
  - Hold iRedirReady=0 for 3 cycles: redirect stays stable and oReady=0.
  - Then iRedirReady=1: oRedirValid=0 and oReady=1 on the following cycle.
- JAL with iRdEn=1, prediction correct (target 0x2000), iLinkPc=0x0FFC -> oWbValid=1 with oWbData=0x0FFC, and no redirect.
- JALR with iPredTaken=1, iPredTgt=0x3000, iTgtAddr=0x3005 -> tgt=0x3004 mismatches 0x3000, so a redirect to 0x3004 is issued.
- Not-taken mispredict: iBjEn=0, iPredTaken=1, iSeqPc=0x404 -> oRedirPc=0x404.
  - Preload the counter to all-ones via repeated mispredicts (CNT_WIDTH=4): the 16th mispredict leaves it at 0xF.
- Macro defined, taken target 0x1002, iPc=0x800 -> oExcValid=1 with oExcTval=0x1002 and oExcPc=0x800, oFlush=1, oRedirValid=0.
  - Also assert iRstN=0 during WAIT: oRedirValid=0 on the next edge.
